// File: rtl/dwc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dwc_pkg
// Description : Shared types for the dual-core result checker. Holds the
//               controller state encoding and the fault reason codes.
// Revision    : 1.0 - initial release
// ============================================================================
package dwc_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        COMPARE = 3'd2,
        OUTPUT  = 3'd3,
        RETRY   = 3'd4,
        FAULT   = 3'd5
    } dwc_state_t;

    // Fault reason reported on fault_code.
    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISMATCH = 2'd1,
        FLT_TIMEOUT  = 2'd2
    } dwc_fault_t;

    // Mismatch counter width and its saturation value.
    localparam int          c_MISMATCH_W   = 8;
    localparam logic [7:0]  c_MISMATCH_MAX = 8'hFF;

endpackage : dwc_pkg
`default_nettype wire

// File: rtl/dwc_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwc_timer
// Description : Capture-window timer. Counts enabled cycles after a clear and
//               flags expiry once the count reaches TIMEOUT_CYC-1. The count
//               stops at the expiry value so expired stays asserted.
// Ports       : clk     - clock
//               reset   - synchronous active-high reset
//               clear   - synchronous restart of the count at zero
//               enable  - advance the count this cycle
//               expired - count has reached TIMEOUT_CYC-1
// Revision    : 1.0 - initial release
// ============================================================================
module dwc_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign expired = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule : dwc_timer
`default_nettype wire

// File: rtl/dwc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dwc_ctrl
// Description : Dual-core lockstep result checker. Collects one result from
//               each core, compares them, forwards the A copy on a match,
//               requests a re-execution on a mismatch (up to MAX_RETRY times)
//               and raises a sticky interrupt on persistent mismatch or when
//               the second result does not arrive within TIMEOUT_CYC cycles.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               a_valid/a_data/a_ready  - core A result handshake
//               b_valid/b_data/b_ready  - core B result handshake
//               out_valid/out_data/out_ready - checked result handshake
//               retry_req               - one-cycle re-execute pulse
//               irq, irq_clear          - sticky fault interrupt and its ack
//               fault_code              - 0 none, 1 mismatch, 2 timeout
//               mismatch_cnt            - saturating lifetime mismatch count
// Revision    : 1.0 - initial release
// ============================================================================
module dwc_ctrl
    import dwc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              retry_req,
    output logic              irq,
    input  logic              irq_clear,
    output logic [1:0]        fault_code,
    output logic [7:0]        mismatch_cnt
);

    localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_RTY_W-1:0] c_RTY_MAX = c_RTY_W'(MAX_RETRY);

    // Registered state
    dwc_state_t              r_state;
    logic [DATA_W-1:0]       r_a_reg;
    logic [DATA_W-1:0]       r_b_reg;
    logic                    r_a_cap;
    logic                    r_b_cap;
    logic [c_RTY_W-1:0]      r_retry_cnt;
    dwc_fault_t              r_fault_code;
    logic [c_MISMATCH_W-1:0] r_mismatch_cnt;

    // Next-state values
    dwc_state_t              w_state_nxt;
    logic [DATA_W-1:0]       w_a_reg_nxt;
    logic [DATA_W-1:0]       w_b_reg_nxt;
    logic                    w_a_cap_nxt;
    logic                    w_b_cap_nxt;
    logic [c_RTY_W-1:0]      w_retry_cnt_nxt;
    dwc_fault_t              w_fault_code_nxt;
    logic [c_MISMATCH_W-1:0] w_mismatch_cnt_nxt;

    logic w_collecting;
    logic w_a_fire;
    logic w_b_fire;
    logic w_expired;

    // ------------------------------------------------------------------
    // Moore outputs: everything follows the registered state, so a reset
    // returns every output to its idle value on the following edge.
    // ------------------------------------------------------------------
    assign w_collecting = (r_state == IDLE) || (r_state == COLLECT);
    assign a_ready      = w_collecting && !r_a_cap;
    assign b_ready      = w_collecting && !r_b_cap;
    assign w_a_fire     = a_valid && a_ready;
    assign w_b_fire     = b_valid && b_ready;

    assign out_valid    = (r_state == OUTPUT);
    assign out_data     = out_valid ? r_a_reg : '0;
    assign retry_req    = (r_state == RETRY);
    assign irq          = (r_state == FAULT);
    assign fault_code   = r_fault_code;
    assign mismatch_cnt = r_mismatch_cnt;

    // The window timer runs only while waiting for the second result and is
    // held at zero otherwise, so entering COLLECT always starts from zero.
    dwc_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state != COLLECT),
        .enable  (r_state == COLLECT),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_a_reg        <= '0;
            r_b_reg        <= '0;
            r_a_cap        <= 1'b0;
            r_b_cap        <= 1'b0;
            r_retry_cnt    <= '0;
            r_fault_code   <= FLT_NONE;
            r_mismatch_cnt <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_a_reg        <= w_a_reg_nxt;
            r_b_reg        <= w_b_reg_nxt;
            r_a_cap        <= w_a_cap_nxt;
            r_b_cap        <= w_b_cap_nxt;
            r_retry_cnt    <= w_retry_cnt_nxt;
            r_fault_code   <= w_fault_code_nxt;
            r_mismatch_cnt <= w_mismatch_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_a_reg_nxt        = r_a_reg;
        w_b_reg_nxt        = r_b_reg;
        w_a_cap_nxt        = r_a_cap;
        w_b_cap_nxt        = r_b_cap;
        w_retry_cnt_nxt    = r_retry_cnt;
        w_fault_code_nxt   = r_fault_code;
        w_mismatch_cnt_nxt = r_mismatch_cnt;

        // Ready is only high in IDLE/COLLECT, so captures happen only there.
        if (w_a_fire) begin
            w_a_reg_nxt = a_data;
            w_a_cap_nxt = 1'b1;
        end
        if (w_b_fire) begin
            w_b_reg_nxt = b_data;
            w_b_cap_nxt = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_a_cap_nxt && w_b_cap_nxt) begin
                    w_state_nxt = COMPARE;
                end else if (w_a_cap_nxt || w_b_cap_nxt) begin
                    w_state_nxt = COLLECT;
                end
            end

            COLLECT: begin
                // A second capture in the expiry cycle takes priority.
                if (w_a_cap_nxt && w_b_cap_nxt) begin
                    w_state_nxt = COMPARE;
                end else if (w_expired) begin
                    w_state_nxt      = FAULT;
                    w_fault_code_nxt = FLT_TIMEOUT;
                end
            end

            COMPARE: begin
                if (r_a_reg == r_b_reg) begin
                    w_state_nxt = OUTPUT;
                end else begin
                    if (r_mismatch_cnt != c_MISMATCH_MAX) begin
                        w_mismatch_cnt_nxt = r_mismatch_cnt + 8'd1;
                    end
                    if (r_retry_cnt < c_RTY_MAX) begin
                        w_state_nxt = RETRY;
                    end else begin
                        w_state_nxt      = FAULT;
                        w_fault_code_nxt = FLT_MISMATCH;
                    end
                end
            end

            OUTPUT: begin
                if (out_ready) begin
                    w_state_nxt     = IDLE;
                    w_a_cap_nxt     = 1'b0;
                    w_b_cap_nxt     = 1'b0;
                    w_retry_cnt_nxt = '0;
                end
            end

            RETRY: begin
                w_state_nxt     = IDLE;
                w_a_cap_nxt     = 1'b0;
                w_b_cap_nxt     = 1'b0;
                w_retry_cnt_nxt = r_retry_cnt + c_RTY_W'(1);
            end

            FAULT: begin
                if (irq_clear) begin
                    w_state_nxt      = IDLE;
                    w_fault_code_nxt = FLT_NONE;
                    w_retry_cnt_nxt  = '0;
                    w_a_cap_nxt      = 1'b0;
                    w_b_cap_nxt      = 1'b0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_a_cap_nxt = 1'b0;
                w_b_cap_nxt = 1'b0;
            end
        endcase
    end

endmodule : dwc_ctrl
`default_nettype wire

// File: tb/tb_dwc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dwc_ctrl
// Description : Directed self-checking bench for dwc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dwc_ctrl;

    localparam int c_DATA_W = 32;

    logic                clk;
    logic                reset;
    logic                a_valid;
    logic [c_DATA_W-1:0] a_data;
    logic                a_ready;
    logic                b_valid;
    logic [c_DATA_W-1:0] b_data;
    logic                b_ready;
    logic                out_valid;
    logic [c_DATA_W-1:0] out_data;
    logic                out_ready;
    logic                retry_req;
    logic                irq;
    logic                irq_clear;
    logic [1:0]          fault_code;
    logic [7:0]          mismatch_cnt;

    int n_cmp;
    int n_err;

    dwc_ctrl #(
        .DATA_W      (c_DATA_W),
        .TIMEOUT_CYC (16),
        .MAX_RETRY   (2)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .retry_req    (retry_req),
        .irq          (irq),
        .irq_clear    (irq_clear),
        .fault_code   (fault_code),
        .mismatch_cnt (mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, ".a_ready"},   32'(a_ready),   32'd1);
        check_val({tag, ".b_ready"},   32'(b_ready),   32'd1);
        check_val({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, ".out_data"},  out_data,       32'd0);
        check_val({tag, ".retry_req"}, 32'(retry_req), 32'd0);
        check_val({tag, ".irq"},       32'(irq),       32'd0);
    endtask

    // Both cores present results in the same cycle, then drop valid.
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        a_valid = 1'b1; a_data = a;
        b_valid = 1'b1; b_data = b;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        out_ready = 1'b1;
        irq_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state ----------------
        check_idle_outputs("rst");
        check_val("rst.fault_code", 32'(fault_code), 32'd0);
        check_val("rst.mismatch_cnt", 32'(mismatch_cnt), 32'd0);

        // ---------------- A then B two cycles later ----------------
        a_valid = 1'b1; a_data = 32'h2;
        tick();                                   // A captured
        a_valid = 1'b0;
        check_val("seq.a_ready_after_cap", 32'(a_ready), 32'd0);
        check_val("seq.b_ready_waiting",   32'(b_ready), 32'd1);
        tick();                                   // COLLECT
        b_valid = 1'b1; b_data = 32'h2;
        tick();                                   // B captured -> COMPARE
        b_valid = 1'b0;
        check_val("seq.cmp_out_valid", 32'(out_valid), 32'd0);
        check_val("seq.cmp_b_ready",   32'(b_ready),   32'd0);
        tick();                                   // OUTPUT
        check_val("seq.out_valid", 32'(out_valid), 32'd1);
        check_val("seq.out_data",  out_data,       32'h2);
        tick();                                   // handshake -> IDLE
        check_idle_outputs("seq.back_idle");

        // ---------------- same-cycle capture, stalled downstream ----------------
        out_ready = 1'b0;
        send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);  // -> COMPARE
        check_val("same.cmp_out_valid", 32'(out_valid), 32'd0);
        check_val("same.cmp_a_ready",   32'(a_ready),   32'd0);
        tick();                                   // OUTPUT
        check_val("same.out_valid", 32'(out_valid), 32'd1);
        check_val("same.out_data",  out_data,       32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1; a_data = 32'h1234;
            tick();
            check_val("stall.out_valid", 32'(out_valid), 32'd1);
            check_val("stall.out_data",  out_data,       32'hFFFF_FFFF);
            check_val("stall.a_ready",   32'(a_ready),   32'd0);
            check_val("stall.b_ready",   32'(b_ready),   32'd0);
        end
        a_valid = 1'b0;
        out_ready = 1'b1;
        tick();                                   // handshake -> IDLE
        check_idle_outputs("same.back_idle");

        // ---------------- persistent mismatch ----------------
        send_pair(32'hFFFF_FFFF, 32'h0);
        tick();                                   // RETRY
        check_val("mm1.retry_req",    32'(retry_req),    32'd1);
        check_val("mm1.mismatch_cnt", 32'(mismatch_cnt), 32'd1);
        tick();                                   // IDLE
        check_val("mm1.retry_pulse_end", 32'(retry_req), 32'd0);
        send_pair(32'hFFFF_FFFF, 32'h0);
        tick();
        check_val("mm2.retry_req",    32'(retry_req),    32'd1);
        check_val("mm2.mismatch_cnt", 32'(mismatch_cnt), 32'd2);
        tick();
        send_pair(32'hFFFF_FFFF, 32'h0);
        tick();                                   // FAULT
        check_val("mm3.retry_req",    32'(retry_req),    32'd0);
        check_val("mm3.irq",          32'(irq),          32'd1);
        check_val("mm3.fault_code",   32'(fault_code),   32'd1);
        check_val("mm3.mismatch_cnt", 32'(mismatch_cnt), 32'd3);
        tick();
        tick();
        check_val("mm3.irq_sticky", 32'(irq),     32'd1);
        check_val("mm3.no_ready",   32'(a_ready), 32'd0);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check_idle_outputs("mm.cleared");
        check_val("mm.clr_fault_code",   32'(fault_code),   32'd0);
        check_val("mm.clr_mismatch_cnt", 32'(mismatch_cnt), 32'd3);
        // Retry budget restarts after the clear.
        send_pair(32'h5, 32'h6);
        tick();
        check_val("mm4.retry_req",    32'(retry_req),    32'd1);
        check_val("mm4.mismatch_cnt", 32'(mismatch_cnt), 32'd4);
        tick();

        // ---------------- timeout ----------------
        a_valid = 1'b1; a_data = 32'hA5;
        tick();                                   // A captured, timer at 0
        a_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_val("to.irq_early", 32'(irq), 32'd0);
        end
        tick();                                   // 16 cycles after capture
        check_val("to.irq",        32'(irq),        32'd1);
        check_val("to.fault_code", 32'(fault_code), 32'd2);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check_idle_outputs("to.cleared");
        check_val("to.clr_fault_code", 32'(fault_code), 32'd0);

        // Second capture lands exactly in the expiry cycle.
        a_valid = 1'b1; a_data = 32'h77;
        tick();
        a_valid = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        b_valid = 1'b1; b_data = 32'h77;
        tick();                                   // COMPARE, not FAULT
        b_valid = 1'b0;
        check_val("edge.irq",        32'(irq),        32'd0);
        check_val("edge.fault_code", 32'(fault_code), 32'd0);
        check_val("edge.out_valid",  32'(out_valid),  32'd0);
        tick();
        check_val("edge.out_valid_next", 32'(out_valid), 32'd1);
        check_val("edge.out_data",       out_data,        32'h77);
        tick();

        // ---------------- reset in COLLECT ----------------
        a_valid = 1'b1; a_data = 32'h9;
        tick();
        a_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("rstc");
        check_val("rstc.mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        // Earlier A was discarded: B alone must only reach COLLECT.
        b_valid = 1'b1; b_data = 32'h9;
        tick();
        b_valid = 1'b0;
        check_val("rstc.a_ready_still", 32'(a_ready), 32'd1);
        tick();
        check_val("rstc.no_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ---------------- reset in OUTPUT ----------------
        out_ready = 1'b0;
        send_pair(32'h33, 32'h33);
        tick();
        check_val("rsto.out_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("rsto");
        tick();
        check_val("rsto.out_valid_post", 32'(out_valid), 32'd0);
        check_val("rsto.retry_post",     32'(retry_req), 32'd0);
        out_ready = 1'b1;

        // ---------------- irq_clear in IDLE ----------------
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check_idle_outputs("clr_idle");
        check_val("clr_idle.fault_code", 32'(fault_code), 32'd0);
        // B before A ordering still completes normally.
        b_valid = 1'b1; b_data = 32'hC0DE;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1; a_data = 32'hC0DE;
        tick();
        a_valid = 1'b0;
        tick();
        check_val("ba.out_valid", 32'(out_valid), 32'd1);
        check_val("ba.out_data",  out_data,       32'hC0DE);
        tick();
        check_val("ba.idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dwc_ctrl
`default_nettype wire
